// File: rtl/enc_event_pkg.sv
// enc_event_pkg: shared widths and the code type for the encoder event FIFO
package enc_event_pkg;
    localparam int CODE_W_DEF = 2;
    localparam int DEPTH_DEF = 4;
    typedef logic [CODE_W_DEF-1:0] code_t;
endpackage

// File: rtl/enc_event_fifo_if.sv
// enc_event_fifo_if: encoder input and FWFT valid/ready read port
interface enc_event_fifo_if import enc_event_pkg::*; #(parameter int CODE_W = CODE_W_DEF);
    logic [CODE_W-1:0] enc_code;
    logic enc_valid;
    logic [CODE_W-1:0] m_data;
    logic m_valid;
    logic m_ready;
    modport master (output enc_code, enc_valid, m_ready, input m_data, m_valid);
    modport slave (input enc_code, enc_valid, m_ready, output m_data, m_valid);
endinterface

// File: rtl/enc_sync_fifo.sv
// enc_sync_fifo: first-word-fall-through synchronous FIFO with registered count/full/empty
module enc_sync_fifo #(
    parameter int W = 2,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [CW-1:0] count,
    output logic full,
    output logic empty
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    logic [CW-1:0] cnt_n;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        cnt_n = count + CW'(do_push) - CW'(do_pop);
    end
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= cnt_n;
            full <= cnt_n == CW'(DEPTH);
            empty <= cnt_n == '0;
        end
    end
endmodule

// File: rtl/enc_event_fifo.sv
// enc_event_fifo: registers encoder output, detects new-code events and queues them
// CODE_HIST_EN adds per-code saturating event counters with hist_clr/hist_cnt ports
module enc_event_fifo import enc_event_pkg::*; #(
    parameter int CODE_W = CODE_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    enc_event_fifo_if.slave bus,
    output logic [$clog2(DEPTH):0] count,
    output logic full,
    output logic empty,
    output logic overflow,
`ifdef CODE_HIST_EN
    input logic hist_clr,
    output logic [(2**CODE_W)*CNT_W-1:0] hist_cnt,
`endif
    input logic clr_ovf
);
    logic [CODE_W-1:0] code_q, prev_code;
    logic valid_q, prev_valid;
    logic ev, pop, drop;
    assign ev = valid_q && (!prev_valid || code_q != prev_code);
    assign pop = bus.m_valid && bus.m_ready;
    assign drop = ev && full && !pop;
    assign bus.m_valid = !empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            valid_q <= 1'b0;
            prev_code <= '0;
            prev_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            code_q <= bus.enc_code;
            valid_q <= bus.enc_valid;
            prev_code <= code_q;
            prev_valid <= valid_q;
            overflow <= drop || (overflow && !clr_ovf);
        end
    end
    enc_sync_fifo #(.W(CODE_W), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(ev),
        .pop(bus.m_ready),
        .din(code_q),
        .dout(bus.m_data),
        .count(count),
        .full(full),
        .empty(empty)
    );
`ifdef CODE_HIST_EN
    logic [CNT_W-1:0] hist [2**CODE_W];
    // dropped events still count; a clear in the same cycle swallows the event
    always_ff @(posedge clk) begin
        if (rst || hist_clr) begin
            for (int i = 0; i < 2**CODE_W; i++) hist[i] <= '0;
        end else if (ev && hist[code_q] != '1) begin
            hist[code_q] <= hist[code_q] + CNT_W'(1);
        end
    end
    for (genvar g = 0; g < 2**CODE_W; g++) begin : g_hist
        assign hist_cnt[g*CNT_W +: CNT_W] = hist[g];
    end
`endif
endmodule

// File: tb/tb_enc_event_fifo.sv
// tb_enc_event_fifo: directed stimulus with an expected-code scoreboard and pop monitor
module tb_enc_event_fifo;
    import enc_event_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_ovf = 1'b0;
    logic [2:0] count;
    logic full, empty, overflow;
    logic hist_clr = 1'b0;
    logic [7:0] hist_cnt;
    int tests = 0;
    int fails = 0;
    code_t sb[$];
    enc_event_fifo_if #(.CODE_W(2)) bus();
    enc_event_fifo #(.CODE_W(2), .DEPTH(4), .CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow),
`ifdef CODE_HIST_EN
        .hist_clr(hist_clr),
        .hist_cnt(hist_cnt),
`endif
        .clr_ovf(clr_ovf)
    );
`ifndef CODE_HIST_EN
    assign hist_cnt = '0;
`endif
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int code, input int valid, input int n);
        bus.enc_code = code_t'(code);
        bus.enc_valid = valid[0];
        step(n);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", int'(bus.m_data), int'(sb.pop_front()));
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enc_code = '0;
        bus.enc_valid = 1'b0;
        bus.m_ready = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_m_data", int'(bus.m_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);

        // single held code gives one event, visible two edges later
        drive(2, 1, 1);
        chk("lat_m_valid_early", int'(bus.m_valid), 0);
        sb.push_back(code_t'(2));
        step(1);
        chk("lat_m_valid", int'(bus.m_valid), 1);
        chk("lat_m_data", int'(bus.m_data), 2);
        chk("lat_count", int'(count), 1);
        step(8);
        chk("hold_count", int'(count), 1);
        bus.enc_valid = 1'b0;
        bus.m_ready = 1'b1;
        step(1);
        bus.m_ready = 1'b0;
        chk("drain_empty", int'(empty), 1);
        step(2);

        // 0 -> 1 -> invalid -> 1 -> 3 fills the FIFO
        sb.push_back(code_t'(0));
        sb.push_back(code_t'(1));
        sb.push_back(code_t'(1));
        sb.push_back(code_t'(3));
        drive(0, 1, 3);
        drive(1, 1, 3);
        drive(0, 0, 1);
        drive(1, 1, 3);
        drive(3, 1, 3);
        drive(0, 0, 3);
        chk("fill_count", int'(count), 4);
        chk("fill_full", int'(full), 1);
        chk("fill_empty", int'(empty), 0);

        // drop while full, then push+pop while full
        drive(2, 1, 3);
        chk("drop_overflow", int'(overflow), 1);
        chk("drop_count", int'(count), 4);
        drive(0, 1, 1);
        sb.push_back(code_t'(0));
        bus.m_ready = 1'b1;
        step(1);
        bus.m_ready = 1'b0;
        chk("pushpop_count", int'(count), 4);
        chk("pushpop_full", int'(full), 1);
        step(1);
        drive(3, 1, 1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("set_wins_overflow", int'(overflow), 1);
        drive(0, 0, 1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("clr_overflow", int'(overflow), 0);
        chk("clr_count", int'(count), 4);
        bus.m_ready = 1'b1;
        step(1);
        bus.m_ready = 1'b0;
        chk("pre_rst_count", int'(count), 3);

        // reset flushes; a code held across reset gives one event afterwards
        bus.enc_code = code_t'(1);
        bus.enc_valid = 1'b1;
        rst = 1'b1;
        sb.delete();
        step(1);
        chk("flush_count", int'(count), 0);
        chk("flush_m_valid", int'(bus.m_valid), 0);
        rst = 1'b0;
        sb.push_back(code_t'(1));
        step(2);
        chk("post_rst_count", int'(count), 1);
        chk("post_rst_m_data", int'(bus.m_data), 1);
        step(3);
        chk("post_rst_hold", int'(count), 1);
        bus.m_ready = 1'b1;
        step(1);
        bus.m_ready = 1'b0;
        drive(0, 0, 2);

`ifdef CODE_HIST_EN
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(code_t'(3));
            drive(3, 1, 1);
            drive(0, 0, 1);
        end
        step(3);
        chk("hist_sat", int'(hist_cnt[7:6]), 3);
        chk("hist_code1", int'(hist_cnt[3:2]), 1);
        sb.push_back(code_t'(3));
        drive(3, 1, 1);
        hist_clr = 1'b1;
        step(1);
        hist_clr = 1'b0;
        drive(0, 0, 3);
        chk("hist_clr_wins", int'(hist_cnt[7:6]), 0);
        chk("hist_all_clear", int'(hist_cnt), 0);
        bus.m_ready = 1'b0;
`endif

        chk("end_empty", int'(empty), 1);
        chk("end_scoreboard", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
